// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter in front of one UART TX shifter (IDLE->SEND->GAP); grant registered 1 cycle after req_valid.
// Requests wait while a frame is in flight; define UART_TX_ARB_TIMEOUT_EN to abort a SEND that never sees tx_done.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_frame_ready,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int ID_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] last_ptr;
   logic [ID_W-1:0] win_idx;
   logic            any_req;
   logic            grant;
   logic            abort;
   logic            to_hit;

   // Nearest set bit after ptr wins; scanning far-to-near lets the closest overwrite.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] pick;
      int unsigned     idx;
      pick = ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (32'(ptr) + 32'(k)) % NUM_REQ;
         if (vld[ID_W'(idx)])
            pick = ID_W'(idx);
      end
      return pick;
   endfunction

   assign any_req = |req_valid;
   assign win_idx = rr_pick(req_valid, last_ptr);

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] to_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         to_cnt <= '0;
      else if (state != SEND)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   assign to_hit = (state == SEND) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = SEND;
               grant     = 1'b1;
            end
         end
         SEND: begin
            if (tx_done) begin
               state_nxt = GAP;
            end else if (to_hit) begin
               state_nxt = GAP;
               abort     = 1'b1;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // last_ptr tracks grant_id but resets to the top index so requester 0 wins first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         last_ptr       <= ID_W'(NUM_REQ - 1);
         req_ready      <= '0;
         tx_frame_ready <= 1'b0;
         tx_data        <= '0;
         grant_id       <= '0;
         busy           <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         state          <= state_nxt;
         req_ready      <= grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
         tx_frame_ready <= (state_nxt == SEND);
         busy           <= (state_nxt != IDLE);
         timeout_err    <= abort;
         if (grant) begin
            tx_data  <= req_data[win_idx*DATA_W +: DATA_W];
            grant_id <= win_idx;
            last_ptr <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, frame timing, reset abort and timeout option.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_frame_ready;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        busy;
   logic        timeout_err;

   int tests = 0;
   int fails = 0;

   uart_tx_arbiter #(
      .NUM_REQ(4),
      .DATA_W(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .tx_frame_ready(tx_frame_ready),
      .tx_data(tx_data),
      .tx_done(tx_done),
      .grant_id(grant_id),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant edge, len SEND cycles, GAP, IDLE; leaves the DUT just after the IDLE edge.
   task automatic do_frame(input string tag, input int id, input logic [7:0] data, input int len);
      int bad;
      tick();
      chk({tag, "_ready"}, req_ready, 32'(1 << id));
      chk({tag, "_gid"}, grant_id, id);
      chk({tag, "_data"}, tx_data, data);
      chk({tag, "_frame"}, tx_frame_ready, 1);
      chk({tag, "_busy"}, busy, 1);
      bad = 0;
      for (int i = 1; i < len; i++) begin
         tick();
         if (tx_frame_ready !== 1'b1 || req_ready !== 4'b0000 || tx_data !== data || grant_id !== 2'(id))
            bad++;
      end
      chk({tag, "_send_hold"}, bad, 0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk({tag, "_gap_frame"}, tx_frame_ready, 0);
      chk({tag, "_gap_busy"}, busy, 1);
      chk({tag, "_gap_err"}, timeout_err, 0);
      tick();
      chk({tag, "_idle_frame"}, tx_frame_ready, 0);
      chk({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      int bad;
      reset_n   = 1'b0;
      req_valid = 4'b0000;
      req_data  = 32'h4433_2211;
      tx_done   = 1'b0;
      repeat (3) tick();

      chk("rst_ready", req_ready, 0);
      chk("rst_frame", tx_frame_ready, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", timeout_err, 0);
      reset_n = 1'b1;

      // All four requesters held valid: strict rotation starting at 0.
      req_valid = 4'b1111;
      do_frame("rr0", 0, 8'h11, 3);
      do_frame("rr1", 1, 8'h22, 3);
      do_frame("rr2", 2, 8'h33, 3);
      do_frame("rr3", 3, 8'h44, 3);
      do_frame("rrwrap", 0, 8'h11, 2);
      req_valid = 4'b0000;

      // Lone requester 2, ten-cycle frame.
      req_data  = 32'h44A5_2211;
      req_valid = 4'b0100;
      do_frame("solo2", 2, 8'hA5, 10);
      req_valid = 4'b0000;
      tick();
      chk("solo2_after_busy", busy, 0);
      chk("solo2_after_ready", req_ready, 0);

      // tx_done while IDLE does nothing.
      tx_done = 1'b1;
      tick();
      chk("idle_done_busy", busy, 0);
      chk("idle_done_frame", tx_frame_ready, 0);
      chk("idle_done_data", tx_data, 8'hA5);
      chk("idle_done_gid", grant_id, 2);
      tx_done   = 1'b0;
      req_data  = 32'h4433_2211;
      req_valid = 4'b0001;
      tick();
      chk("wrap_gid", grant_id, 0);
      chk("wrap_ready", req_ready, 4'b0001);
      chk("wrap_data", tx_data, 8'h11);
      req_valid = 4'b1110;
      tick();
      chk("send_ignore_gid", grant_id, 0);
      chk("send_ignore_ready", req_ready, 0);
      chk("send_ignore_frame", tx_frame_ready, 1);
      tx_done = 1'b1;
      tick();
      chk("gap_busy", busy, 1);
      chk("gap_frame", tx_frame_ready, 0);
      tick();
      chk("gap_done_busy", busy, 0);
      chk("gap_done_ready", req_ready, 0);
      chk("gap_done_gid", grant_id, 0);
      tx_done = 1'b0;

      // Requester 1 granted, then reset mid-SEND.
      tick();
      chk("pre_rst_gid", grant_id, 1);
      chk("pre_rst_data", tx_data, 8'h22);
      tick();
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_frame", tx_frame_ready, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_err", timeout_err, 0);
      chk("midrst_data", tx_data, 0);
      req_valid = 4'b1111;
      tick();
      reset_n = 1'b1;
      do_frame("post_rst", 0, 8'h11, 2);
      req_valid = 4'b0000;
      tick();

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Requesters 1 and 2 held; frame 1 times out after 16 cycles.
      req_valid = 4'b0110;
      tick();
      chk("to_gid", grant_id, 1);
      chk("to_ready", req_ready, 4'b0010);
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (tx_frame_ready !== 1'b1 || timeout_err !== 1'b0) bad++;
         tick();
      end
      chk("to_send_16", bad, 0);
      chk("to_last_frame", tx_frame_ready, 1);
      tick();
      chk("to_err_pulse", timeout_err, 1);
      chk("to_gap_frame", tx_frame_ready, 0);
      chk("to_gap_busy", busy, 1);
      tick();
      chk("to_err_clear", timeout_err, 0);
      chk("to_idle_busy", busy, 0);
      tick();
      chk("to_next_gid", grant_id, 2);
      chk("to_next_ready", req_ready, 4'b0100);
      req_valid = 4'b0000;
      repeat (15) tick();
      chk("to_edge_frame", tx_frame_ready, 1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("to_edge_err", timeout_err, 0);
      chk("to_edge_frame_off", tx_frame_ready, 0);
      tick();
      chk("to_edge_err2", timeout_err, 0);
`else
      // No timeout: SEND holds for 1000 cycles without tx_done.
      req_valid = 4'b0010;
      tick();
      chk("notimeo_gid", grant_id, 1);
      req_valid = 4'b0000;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (tx_frame_ready !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("notimeo_hold", bad, 0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("notimeo_gap_frame", tx_frame_ready, 0);
      chk("notimeo_gap_err", timeout_err, 0);
      tick();
      chk("notimeo_idle_busy", busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, payload bits per frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 120000, SEND-state cycle limit (used only under REQ-027).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte-pending flag, held until accepted.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  requester i payload in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot single-cycle accept pulse.
REQ-009 SHALL have port tx_frame_ready  output  1  enable to TX baud counter/shifter, high for whole frame.
REQ-010 SHALL have port tx_data  output  DATA_W  latched payload of granted requester.
REQ-011 SHALL have port tx_done  input  1  end-of-frame pulse from TX baud counter.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of current/last granted requester.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, GAP; all outputs registered.
REQ-016 IDLE: at a clock edge where any req_valid bit is 1, SHALL select winner round-robin, searching from (last_ptr+1) mod NUM_REQ upward with wrap.
REQ-017 On that edge SHALL latch req_data of winner into tx_data, set grant_id, set last_ptr to winner, enter SEND.
REQ-018 req_ready[winner] SHALL be 1 exactly in the first SEND cycle (latency 1 cycle from sampled req_valid); all other bits 0.
REQ-019 tx_frame_ready SHALL be 1 in every SEND cycle and 0 in IDLE and GAP.
REQ-020 tx_data SHALL stay stable from SEND entry until the next grant.
REQ-021 SEND: on tx_done=1 SHALL go to GAP; changes on req_valid during SEND SHALL be ignored.
REQ-022 GAP: lasts exactly 1 cycle, then IDLE; guarantees tx_frame_ready low for at least 2 cycles between frames so the baud counter restarts.
REQ-023 tx_done in IDLE or GAP SHALL be ignored.
REQ-024 Back-to-back: a request pending during SEND SHALL be granted on the first IDLE edge; frame-to-frame tx_frame_ready gap = 2 cycles.
REQ-025 Single requester continuously valid SHALL be regranted every frame; no requester SHALL wait more than NUM_REQ-1 frames while others are valid.

Reset
REQ-026 On reset_n=0, asynchronously: state=IDLE, last_ptr=NUM_REQ-1 (requester 0 wins first), req_ready=0, tx_frame_ready=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, timeout counter=0; reset mid-SEND SHALL drop tx_frame_ready immediately with no req_ready pulse or timeout_err.

Configuration
REQ-027 With macro UART_TX_ARB_TIMEOUT_EN defined: a counter SHALL clear on SEND entry and increment each SEND cycle; if it reaches TIMEOUT_CYCLES-1 without tx_done, FSM SHALL enter GAP and pulse timeout_err for 1 cycle (tx_done in the same cycle takes priority, no error).
REQ-028 Without UART_TX_ARB_TIMEOUT_EN: no counter SHALL be synthesized, SEND waits indefinitely for tx_done, timeout_err tied to 0.

Verification
REQ-029 After reset, req_valid=4'b1111, data 0x11/0x22/0x33/0x44 -> grants 0,1,2,3 in order, tx_data 0x11,0x22,0x33,0x44, one req_ready pulse each.
REQ-030 Only requester 2 valid, data 0xA5, tx_done 10 cycles after grant -> req_ready=4'b0100 one cycle, tx_frame_ready high 10 cycles, GAP 1 cycle, busy low after.
REQ-031 tx_done pulsed while IDLE and during GAP -> no state change, no output change.
REQ-032 reset_n low for 1 cycle mid-SEND with requester 1 granted -> tx_frame_ready low same cycle; next grant with all valid goes to requester 0.
REQ-033 Macro defined, TIMEOUT_CYCLES=16, tx_done never asserted -> tx_frame_ready high exactly 16 cycles, timeout_err pulses once, next requester granted after GAP.
REQ-034 Macro undefined, tx_done withheld 1000 cycles -> stays in SEND, timeout_err stays 0.
